// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM burst generator and its upstream counter.
// Holds default widths and the burst FSM state type.
package pwm_pkg;

    localparam int CONT_W_DEF = 5;
    localparam int NPER_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/gerador_pwm_duty_shadow.sv
// Double-buffered duty register with a valid/ready input handshake.
// Ports: duty_i/valid_i/ready_o (handshake), load_i (boundary), active_o.
import pwm_pkg::*;

module duty_shadow #(
    parameter int DUTY_W = CONT_W_DEF + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DUTY_W-1:0] duty_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic              load_i,
    output logic [DUTY_W-1:0] active_o
);

    logic [DUTY_W-1:0] shadow_q, shadow_d;
    logic [DUTY_W-1:0] active_q, active_d;
    logic              pend_q, pend_d;
    logic              xfer;

    assign ready_o  = !pend_q;
    assign active_o = active_q;
    assign xfer     = valid_i && !pend_q;

    // A transfer in the same cycle as a boundary with nothing
    // pending only fills the shadow; it goes live one boundary later.
    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        pend_d   = pend_q;
        if (load_i && pend_q) begin
            active_d = shadow_q;
            pend_d   = 1'b0;
        end
        if (xfer) begin
            shadow_d = duty_i;
            pend_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_q <= '0;
            active_q <= '0;
            pend_q   <= 1'b0;
        end else begin
            shadow_q <= shadow_d;
            active_q <= active_d;
            pend_q   <= pend_d;
        end
    end

endmodule

// File: rtl/gerador_pwm.sv
// PWM burst generator driven by the contador counter outputs.
// Ports: contagem/fim in, duty handshake, start/n_periodos, pwm_out/ocupado/concluido.
import pwm_pkg::*;

module gerador_pwm #(
    parameter int CONT_W = CONT_W_DEF,
    parameter int NPER_W = NPER_W_DEF,
    parameter int DUTY_W = CONT_W + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CONT_W-1:0] contagem,
    input  logic              fim,
    input  logic [DUTY_W-1:0] duty_in,
    input  logic              duty_valid,
    output logic              duty_ready,
    input  logic              start,
    input  logic [NPER_W-1:0] n_periodos,
    output logic              pwm_out,
    output logic              ocupado,
    output logic              concluido
);

    state_t            state_q, state_d;
    logic [NPER_W-1:0] cnt_q, cnt_d;
    logic [NPER_W-1:0] nlat_q, nlat_d;
    logic              pwm_q, pwm_d;
    logic              ocup_q, ocup_d;
    logic              conc_q, conc_d;
    logic              load;
    logic [DUTY_W-1:0] active;

    duty_shadow #(
        .DUTY_W (DUTY_W)
    ) u_shadow (
        .clk      (clk),
        .reset    (reset),
        .duty_i   (duty_in),
        .valid_i  (duty_valid),
        .ready_o  (duty_ready),
        .load_i   (load),
        .active_o (active)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        nlat_d  = nlat_q;
        load    = 1'b0;
        conc_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (n_periodos != '0) begin
                        nlat_d  = n_periodos;
                        state_d = ARMED;
                    end else begin
                        conc_d = 1'b1;
                    end
                end
            end
            ARMED: begin
                if (fim) begin
                    load    = 1'b1;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (fim) begin
                    if (cnt_q == nlat_q - NPER_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        cnt_d = cnt_q + NPER_W'(1);
                        load  = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Status outputs are registered from the next state so they
        // line up with the state they describe.
        if (state_d == DONE) begin
            conc_d = 1'b1;
        end
        ocup_d = (state_d == ARMED) || (state_d == RUN);
        pwm_d  = (state_q == RUN) && (DUTY_W'(contagem) < active);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            nlat_q  <= '0;
            pwm_q   <= 1'b0;
            ocup_q  <= 1'b0;
            conc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            nlat_q  <= nlat_d;
            pwm_q   <= pwm_d;
            ocup_q  <= ocup_d;
            conc_q  <= conc_d;
        end
    end

    assign pwm_out   = pwm_q;
    assign ocupado   = ocup_q;
    assign concluido = conc_q;

endmodule

// File: doc/gerador_pwm.md
Name: gerador_pwm

Overview:
- Downstream consumer of the synchronous counter `contador`.
- Takes the counter's `contagem` and `fim` outputs and generates a PWM waveform in bursts of N counter periods.
- Duty cycle is double-buffered through a valid/ready handshake; new values apply only at a counter period boundary.
- Sits between `contador` and the output pad / next logic stage.

Parameters:
- CONT_W, 5, width of `contagem`; must match the counter.
- NPER_W, 8, width of the burst period count.
- DUTY_W, CONT_W+1, duty width; allows duty = 2^CONT_W (100% at full-scale period).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- contagem  input  CONT_W  current counter value from `contador`
- fim  input  1  counter end-of-period strobe; high in the cycle where contagem == valor_maximo
- duty_in  input  DUTY_W  new duty value, in counter ticks
- duty_valid  input  1  duty_in valid
- duty_ready  output  1  shadow register can accept a value
- start  input  1  one-cycle burst request
- n_periodos  input  NPER_W  number of PWM periods in the burst; sampled with start
- pwm_out  output  1  registered PWM output
- ocupado  output  1  high in ARMED and RUN
- concluido  output  1  one-cycle pulse when the burst ends

Behaviour:
- Reset (synchronous):
  - State returns to IDLE.
  - pwm_out=0, ocupado=0, concluido=0, duty_ready=1.
  - Active duty = 0, shadow = 0, pending = 0, period count = 0.
  - Reset asserted mid-burst aborts the burst; concluido is not pulsed.
- Duty handshake:
  - duty_ready = !pending.
  - Transfer occurs when duty_valid && duty_ready: shadow <= duty_in, pending <= 1.
  - At a load boundary with pending=1: active <= shadow, pending <= 0.
  - At a load boundary with pending=0: active is unchanged.
  - A handshake in the same cycle as a boundary with pending=0 is captured into shadow. It applies at the next boundary, not the current one.
  - The handshake is accepted in every state, including IDLE. A pending value persists across bursts.
- States:
  - IDLE:
    - pwm_out=0, `fim` ignored.
    - start with n_periodos != 0: latch n_periodos, go to ARMED.
    - start with n_periodos == 0: pulse concluido next cycle, stay in IDLE.
  - ARMED: wait for fim. That cycle is a load boundary; clear period count, go to RUN. The first PWM period therefore starts at contagem=0.
  - RUN:
    - pwm_out(t+1) = (contagem(t) < active_duty).
    - fim is a boundary. If count == n_latched-1, go to DONE. Otherwise count++ and perform the duty load.
  - DONE: pwm_out=0, concluido=1 for exactly this cycle, go to IDLE.
- Output timing:
  - ocupado is registered and high in ARMED and RUN.
  - start outside IDLE is ignored.
- Output latency is 1 cycle from contagem to pwm_out.
- Duty edge values:
  - duty=0 gives pwm_out constantly 0.
  - duty > valor_maximo gives pwm_out constantly 1 for the period.
- The comparison is unsigned; contagem is zero-extended to DUTY_W.
- fim outside ARMED/RUN has no effect.

Decomposition:
- Shared package `pwm_pkg`:
  - state enum: IDLE, ARMED, RUN, DONE
  - default CONT_W/NPER_W localparams shared with `contador`
- Natural sub-module: `duty_shadow`. It holds the shadow register, pending flag and valid/ready logic, and exposes a load strobe and the active duty.
- The FSM and comparator stay in the top module.

Test Plan:
- Reset, then start=1 with n_periodos=3, duty_in=4 accepted in IDLE; counter driven with valor_maximo=9 -> after the first fim, three periods each with pwm_out high 4 cycles / low 6 cycles; concluido pulses once; ocupado drops on the same edge.
- Burst running with duty=4; duty_in=7 handshaken mid-period -> current period keeps 4 high; next period has 7 high; duty_ready is low from the accept until that boundary.
- duty_in=0, then duty_in=10 with valor_maximo=9 -> one period fully low, one fully high; no glitch at the wrap.
- start with n_periodos=0 in IDLE -> concluido pulse 1 cycle later; ocupado stays 0; pwm_out stays 0.
- start asserted in RUN, and fim toggled in IDLE -> no state change; burst length unchanged (n=2 gives exactly 20 pwm cycles at valor_maximo=9).
- reset asserted in RUN with pwm_out=1 -> next edge: pwm_out=0, ocupado=0, duty_ready=1, no concluido; a new start works normally.
